// File: rtl/mem_port_arbiter.sv
// Two-port (fetch/data) arbiter onto a single fixed-latency memory port.
// Latency: request seen in IDLE to ack is MEM_LATENCY+2 cycles, reads and writes alike.
// Backpressure: requesters hold req until their one-cycle ack; a losing port simply waits.
module mem_port_arbiter #(
    parameter int WORD_SIZE   = 16,
    parameter int MEM_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_req,
    input  logic [WORD_SIZE-1:0] i_addr,
    output logic                 i_ack,
    output logic [WORD_SIZE-1:0] i_rdata,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic                 d_ack,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    output logic                 busy,
    output logic                 grant_d
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    // WAIT spans MEM_LATENCY cycles: load N-1 and leave when the count reaches zero.
    localparam logic [3:0] WAIT_LOAD = 4'(MEM_LATENCY - 1);

    state_t               state_q;
    state_t               state_d;
    logic [3:0]           wait_cnt_q;
    // Owner of the current/most recent grant; doubles as the round-robin
    // last-granted record (0 = instruction, so data wins the first tie).
    logic                 owner_d_q;
    logic                 we_q;
    logic [WORD_SIZE-1:0] addr_q;
    logic [WORD_SIZE-1:0] wdata_q;
    logic [WORD_SIZE-1:0] i_rdata_q;
    logic [WORD_SIZE-1:0] d_rdata_q;
    logic                 grant_vld;
    logic                 grant_sel_d;
    logic                 wait_done;

    assign wait_done = (state_q == WAIT) && (wait_cnt_q == 4'd0);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and grant decision; in RESP only the other port is eligible.
    always_comb begin
        state_d     = state_q;
        grant_vld   = 1'b0;
        grant_sel_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_req && d_req) begin
                    grant_vld   = 1'b1;
                    grant_sel_d = ~owner_d_q;
                end else if (d_req) begin
                    grant_vld   = 1'b1;
                    grant_sel_d = 1'b1;
                end else if (i_req) begin
                    grant_vld   = 1'b1;
                    grant_sel_d = 1'b0;
                end
                if (grant_vld) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (wait_done) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (owner_d_q && i_req) begin
                    grant_vld   = 1'b1;
                    grant_sel_d = 1'b0;
                    state_d     = ACCESS;
                end else if (!owner_d_q && d_req) begin
                    grant_vld   = 1'b1;
                    grant_sel_d = 1'b1;
                    state_d     = ACCESS;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from state and the latched transaction.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        i_ack     = 1'b0;
        d_ack     = 1'b0;
        busy      = (state_q != IDLE);
        grant_d   = (state_q != IDLE) && owner_d_q;
        if (state_q == ACCESS) begin
            mem_write = owner_d_q && we_q;
            mem_read  = ~(owner_d_q && we_q);
        end
        if (state_q == RESP) begin
            i_ack = ~owner_d_q;
            d_ack = owner_d_q;
        end
    end

    // WAIT down-counter, loaded on the way out of ACCESS.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q <= 4'd0;
        end else if (state_q == ACCESS) begin
            wait_cnt_q <= WAIT_LOAD;
        end else if ((state_q == WAIT) && (wait_cnt_q != 4'd0)) begin
            wait_cnt_q <= wait_cnt_q - 4'd1;
        end
    end

    // Latch owner and request fields at grant; memory outputs come only from here.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_d_q <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else if (grant_vld) begin
            owner_d_q <= grant_sel_d;
            we_q      <= grant_sel_d & d_we;
            addr_q    <= grant_sel_d ? d_addr : i_addr;
            wdata_q   <= grant_sel_d ? d_wdata : '0;
        end
    end

    // Capture read data on the last WAIT edge into the owner's hold register.
    always_ff @(posedge clk) begin
        if (reset) begin
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else if (wait_done && !we_q) begin
            if (owner_d_q) begin
                d_rdata_q <= mem_rdata;
            end else begin
                i_rdata_q <= mem_rdata;
            end
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a fixed-latency memory model and ack scoreboard.
// Latency: expects ack MEM_LATENCY+2 (=4) cycles after a request is seen in IDLE.
// Backpressure: requests are held through their expected ack cycle, then dropped or renewed.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        i_req;
    logic [15:0] i_addr;
    logic        i_ack;
    logic [15:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_ack;
    logic [15:0] d_rdata;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        busy;
    logic        grant_d;

    mem_port_arbiter #(.WORD_SIZE(16), .MEM_LATENCY(2)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .grant_d(grant_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          is_d;
        bit          is_rd;
        int          cyc;
        logic [15:0] rdata;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    // Memory model: written locations override a fixed address pattern.
    bit   [15:0] wr_mem   [256];
    bit          wr_valid [256];
    logic [15:0] rd_p0 = 16'hDEAD;
    logic [15:0] rd_p1 = 16'hDEAD;

    function automatic logic [15:0] rd_model(input logic [7:0] a);
        if (wr_valid[a]) return wr_mem[a];
        if (a == 8'h10) return 16'h1234;
        return {a, ~a};
    endfunction

    // Read data appears exactly two cycles after the read strobe, junk otherwise.
    always @(posedge clk) begin
        rd_p0 <= mem_read ? rd_model(mem_addr[7:0]) : 16'hDEAD;
        rd_p1 <= rd_p0;
        if (mem_write) begin
            wr_valid[mem_addr[7:0]] <= 1'b1;
            wr_mem[mem_addr[7:0]]   <= mem_wdata;
        end
    end
    assign mem_rdata = rd_p1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit is_d, input bit is_rd, input int c, input logic [15:0] rdata);
        exp_t e;
        e.is_d  = is_d;
        e.is_rd = is_rd;
        e.cyc   = c;
        e.rdata = rdata;
        sb.push_back(e);
    endtask

    // Advance to the negative edge of cycle t (t must not be in the past).
    task automatic at_cycle(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
    endtask

    // Per-cycle invariants and ack scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            check("inv_rw_excl", 32'(mem_read & mem_write), 32'd0);
            check("inv_ack_excl", 32'(i_ack & d_ack), 32'd0);
            check("inv_ifetch_no_write", 32'(mem_write & ~grant_d), 32'd0);
            check("inv_idle_strobe", 32'((mem_read | mem_write) & ~busy), 32'd0);
            if (i_ack || d_ack) begin
                if (sb.size() == 0) begin
                    check("unexpected_ack", 32'd1, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("ack_port", 32'(d_ack), 32'(mon_e.is_d));
                    check("ack_cycle", 32'(cyc), 32'(mon_e.cyc));
                    if (mon_e.is_rd)
                        check("ack_rdata", 32'(mon_e.is_d ? d_rdata : i_rdata), 32'(mon_e.rdata));
                end
            end
        end
    end

    int c;

    initial begin
        reset   = 1'b1;
        i_req   = 1'b0;
        i_addr  = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mem_read", 32'(mem_read), 32'd0);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_i_ack", 32'(i_ack), 32'd0);
        check("rst_d_ack", 32'(d_ack), 32'd0);
        check("rst_grant_d", 32'(grant_d), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_i_rdata", 32'(i_rdata), 32'd0);
        check("rst_d_rdata", 32'(d_rdata), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Fetch read
        @(posedge clk); #1;
        c = cyc;
        i_req = 1'b1; i_addr = 16'h0010;
        push(1'b0, 1'b1, c + 4, 16'h1234);
        at_cycle(c + 1);
        check("fetch_mem_read", 32'(mem_read), 32'd1);
        check("fetch_mem_write", 32'(mem_write), 32'd0);
        check("fetch_mem_addr", 32'(mem_addr), 32'h0010);
        check("fetch_grant_d", 32'(grant_d), 32'd0);
        at_cycle(c + 4);
        @(posedge clk); #1;
        i_req = 1'b0;

        // Data write
        c = cyc;
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0020; d_wdata = 16'hBEEF;
        push(1'b1, 1'b0, c + 4, 16'h0000);
        at_cycle(c + 1);
        check("wr_mem_write", 32'(mem_write), 32'd1);
        check("wr_mem_read", 32'(mem_read), 32'd0);
        check("wr_mem_addr", 32'(mem_addr), 32'h0020);
        check("wr_mem_wdata", 32'(mem_wdata), 32'hBEEF);
        check("wr_grant_d", 32'(grant_d), 32'd1);
        for (int k = 2; k <= 4; k++) begin
            at_cycle(c + k);
            check("wr_no_read", 32'(mem_read), 32'd0);
            check("wr_single_pulse", 32'(mem_write), 32'd0);
        end
        check("wr_d_rdata_hold", 32'(d_rdata), 32'd0);
        check("wr_i_rdata_hold", 32'(i_rdata), 32'h1234);
        @(posedge clk); #1;
        d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
        check("wr_mem_content", 32'(rd_model(8'h20)), 32'hBEEF);

        // Simultaneous requests after reset: data first
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst2_i_rdata", 32'(i_rdata), 32'd0);
        @(posedge clk); #1;
        c = cyc;
        i_req = 1'b1; i_addr = 16'h0030;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0040;
        push(1'b1, 1'b1, c + 4, rd_model(8'h40));
        push(1'b0, 1'b1, c + 8, rd_model(8'h30));
        at_cycle(c + 1);
        check("tie_grant_d", 32'(grant_d), 32'd1);
        check("tie_mem_addr_d", 32'(mem_addr), 32'h0040);
        at_cycle(c + 4);
        @(posedge clk); #1;
        d_req = 1'b0;
        at_cycle(c + 5);
        check("tie_second_grant", 32'(grant_d), 32'd0);
        check("tie_second_read", 32'(mem_read), 32'd1);
        check("tie_second_addr", 32'(mem_addr), 32'h0030);
        at_cycle(c + 8);
        @(posedge clk); #1;
        i_req = 1'b0;

        // Round-robin under continuous requests
        c = cyc;
        i_req = 1'b1; i_addr = 16'h0060;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0050;
        for (int k = 0; k < 6; k++) begin
            logic [7:0] a;
            a = (k % 2 == 0) ? 8'(8'h50 + k / 2) : 8'(8'h60 + k / 2);
            push(k % 2 == 0, 1'b1, c + 4 * (k + 1), rd_model(a));
        end
        for (int k = 0; k < 6; k++) begin
            at_cycle(c + 4 * k + 1);
            check("rr_grant", 32'(grant_d), 32'(k % 2 == 0));
            check("rr_addr", 32'(mem_addr),
                  (k % 2 == 0) ? 32'(8'h50 + k / 2) : 32'(8'h60 + k / 2));
            at_cycle(c + 4 * k + 4);
            @(posedge clk); #1;
            if (k % 2 == 0) begin
                if (k < 4) d_addr = 16'(16'h0050 + k / 2 + 1);
                else d_req = 1'b0;
            end else begin
                if (k < 5) i_addr = 16'(16'h0060 + (k + 1) / 2);
                else i_req = 1'b0;
            end
        end

        // Reset in the second WAIT cycle of a read; request re-raised as reset drops
        c = cyc;
        i_req = 1'b1; i_addr = 16'h0070;
        at_cycle(c + 1);
        check("abort_mem_read", 32'(mem_read), 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        i_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        i_req = 1'b1; i_addr = 16'h0010;
        push(1'b0, 1'b1, cyc + 4, 16'h1234);
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_i_ack", 32'(i_ack), 32'd0);
        check("abort_i_rdata", 32'(i_rdata), 32'd0);
        check("abort_mem_addr", 32'(mem_addr), 32'd0);
        check("abort_d_rdata", 32'(d_rdata), 32'd0);
        c = cyc;
        at_cycle(c + 4);
        @(posedge clk); #1;
        i_req = 1'b0;

        // Data requester withdraws during WAIT
        c = cyc;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0080;
        push(1'b1, 1'b1, c + 4, rd_model(8'h80));
        @(posedge clk); #1;
        @(posedge clk); #1;
        d_req = 1'b0;
        at_cycle(c + 5);
        check("withdraw_idle", 32'(busy), 32'd0);
        check("withdraw_d_rdata_hold", 32'(d_rdata), 32'(rd_model(8'h80)));

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter WORD_SIZE, default 16: address and data width.
REQ-002 Parameter MEM_LATENCY, default 2: cycles from the memory command cycle to valid mem_rdata; legal range 1..15.
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 i_req  in  1  instruction-fetch read request; held high until i_ack.
REQ-006 i_addr  in  WORD_SIZE  fetch address; stable while i_req=1.
REQ-007 i_ack  out  1  one-cycle pulse: fetch complete, i_rdata valid.
REQ-008 i_rdata  out  WORD_SIZE  fetched word.
REQ-009 d_req  in  1  data request; held high until d_ack.
REQ-010 d_we  in  1  1 = write, 0 = read; stable while d_req=1.
REQ-011 d_addr, d_wdata  in  WORD_SIZE each  data address and write data; stable while d_req=1.
REQ-012 d_ack  out  1  one-cycle pulse: data access complete, d_rdata valid on reads.
REQ-013 d_rdata  out  WORD_SIZE  loaded word.
REQ-014 mem_read, mem_write  out  1 each  one-cycle memory command strobes.
REQ-015 mem_addr, mem_wdata  out  WORD_SIZE each  memory address and write data.
REQ-016 mem_rdata  in  WORD_SIZE  memory read data.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 grant_d  out  1  1 while the current transaction belongs to the data port.

Function
REQ-019 The FSM SHALL have four states: IDLE, ACCESS, WAIT, RESP.
REQ-020 IDLE, no request: stay in IDLE.
REQ-021 IDLE, exactly one request: go to ACCESS and grant that requester.
REQ-022 IDLE, both requests: grant the requester not granted most recently (round-robin).
REQ-023 Grant SHALL latch the owner, address, write data and write flag into internal registers; memory outputs come from these registers only.
REQ-024 ACCESS lasts one cycle.
  - Data write: mem_write=1.
  - Otherwise: mem_read=1.
  - Next state: WAIT.
REQ-025 WAIT lasts exactly MEM_LATENCY cycles, timed by a down-counter.
  - On the final WAIT edge, mem_rdata is captured into the owner's rdata register, reads only.
  - Next state: RESP.
REQ-026 mem_addr and mem_wdata SHALL hold the latched values from ACCESS through the end of WAIT.
REQ-027 RESP lasts one cycle and pulses the owner's ack.
  - The owner's req is ignored during RESP.
  - Other port requesting: go to ACCESS and grant it.
  - Otherwise: go to IDLE.
REQ-028 Latency from req seen in IDLE to ack SHALL be MEM_LATENCY+2 cycles.
  - Reads and writes have the same latency.
REQ-029 i_rdata and d_rdata SHALL hold their last captured value until the next read capture for that port.
REQ-030 A requester dropping req mid-transaction SHALL NOT abort it; the access completes and the ack still pulses.
REQ-031 Invariants, checked every cycle:
  - mem_read and mem_write are never both 1.
  - i_ack and d_ack are never both 1.
  - The instruction port never causes mem_write.
  - Strobes are 0 outside ACCESS.

Reset
REQ-032 While reset=1 at a clock edge, the block SHALL:
  - return to IDLE;
  - clear the WAIT counter;
  - drive every output to 0;
  - set the last-granted record to "instruction", so the data port wins the first tie.
REQ-033 Reset during ACCESS, WAIT or RESP SHALL abandon the transaction with no ack; rdata registers SHALL read 0.
REQ-034 Requests present on the cycle reset deasserts are arbitrated in the following IDLE cycle.

Verification (MEM_LATENCY=2)
REQ-035 Fetch read:
  - Stimulus: i_req with i_addr=0x0010 at cycle 0; memory returns 0x1234.
  - Response: mem_read=1, mem_addr=0x0010 at cycle 1; i_ack=1, i_rdata=0x1234 at cycle 4.
REQ-036 Data write:
  - Stimulus: d_req, d_we=1, d_addr=0x0020, d_wdata=0xBEEF.
  - Response: a single mem_write pulse with those values; d_ack 4 cycles after request; mem_read never asserted.
REQ-037 Simultaneous requests after reset:
  - Stimulus: i_req and d_req at cycle 0.
  - Response: data granted first, d_ack at cycle 4; fetch enters ACCESS at cycle 5, i_ack at cycle 8.
REQ-038 Round-robin:
  - Stimulus: both ports request continuously for 6 transactions.
  - Response: grants alternate D,I,D,I,D,I; ack spacing is 4 cycles.
REQ-039 Reset mid-access:
  - Stimulus: reset asserted in the second WAIT cycle of a read.
  - Response: no ack; outputs 0 next cycle; a fresh i_req completes normally after reset.
REQ-040 Requester withdrawal:
  - Stimulus: d_req dropped during WAIT.
  - Response: d_ack still pulses in RESP; the FSM then goes to IDLE.
